// File: rtl/regfile_write_queue.sv
// Write-back staging FIFO in front of the register file: accepts ALU and load writes,
// drains one per cycle as one-hot wr_en plus D bus. WQ_HAZARD_CHECK_EN adds pending-write lookups.
module regfile_write_queue #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int REG_CNT = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       mem_ready,
    output logic [REG_CNT-1:0]         wr_en,
    output logic [DATA_W-1:0]          wr_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    input  logic [ADDR_W-1:0]          chk_reg1,
    input  logic [ADDR_W-1:0]          chk_reg2,
    output logic                       chk_hit1,
    output logic                       chk_hit2
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] rg;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

    wq_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             mem_push, alu_push, pop;
    logic [PTR_W-1:0] mem_slot, alu_slot;
    wq_entry_t        head_ent;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Ready uses the pre-pop count; the load unit owns the last free slot.
    assign mem_ready = !full;
    assign alu_ready = (count_q <= CNT_W'(DEPTH - 2)) || (!full && !mem_valid);

    // Writes to r0 are accepted but dropped.
    assign mem_push = mem_valid && mem_ready && (mem_reg != '0);
    assign alu_push = alu_valid && alu_ready && (alu_reg != '0);
    assign pop      = !empty;
    assign mem_slot = tail_q;
    assign alu_slot = tail_q + PTR_W'(mem_push);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(mem_push) + PTR_W'(alu_push);
            count_q <= count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
            if (pop) vld_q[head_q] <= 1'b0;
            if (mem_push) begin
                ent_q[mem_slot] <= '{rg: mem_reg, data: mem_data};
                vld_q[mem_slot] <= 1'b1;
            end
            if (alu_push) begin
                ent_q[alu_slot] <= '{rg: alu_reg, data: alu_data};
                vld_q[alu_slot] <= 1'b1;
            end
        end
    end

    assign head_ent = ent_q[head_q];
    assign wr_en    = empty ? '0 : (REG_CNT'(1) << head_ent.rg);
    assign wr_data  = empty ? '0 : head_ent.data;

`ifdef WQ_HAZARD_CHECK_EN
    logic [DEPTH-1:0] hit1_vec, hit2_vec;

    for (genvar e = 0; e < DEPTH; e++) begin : g_cmp
        wq_entry_match #(.ADDR_W(ADDR_W)) u_match (
            .vld       (vld_q[e]),
            .entry_reg (ent_q[e].rg),
            .chk_reg1  (chk_reg1),
            .chk_reg2  (chk_reg2),
            .hit1      (hit1_vec[e]),
            .hit2      (hit2_vec[e])
        );
    end

    assign chk_hit1 = (chk_reg1 != '0) && (|hit1_vec);
    assign chk_hit2 = (chk_reg2 != '0) && (|hit2_vec);
`else
    logic unused_chk;
    assign unused_chk = ^{chk_reg1, chk_reg2, vld_q};
    assign chk_hit1   = 1'b0;
    assign chk_hit2   = 1'b0;
`endif

endmodule

`ifdef WQ_HAZARD_CHECK_EN
// Per-entry register-index match for both hazard-check read ports.
module wq_entry_match #(
    parameter int ADDR_W = 4
) (
    input  logic              vld,
    input  logic [ADDR_W-1:0] entry_reg,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              hit1,
    output logic              hit2
);
    assign hit1 = vld && (entry_reg == chk_reg1);
    assign hit2 = vld && (entry_reg == chk_reg2);
endmodule
`endif

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed vector table, hand sequences for reset and
// hazard lookups, then random traffic against a queue-level reference model.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
`ifdef WQ_HAZARD_CHECK_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk, rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_reg, mem_reg, chk_reg1, chk_reg2;
    logic [15:0] alu_data, mem_data, wr_en, wr_data;
    logic [2:0]  count;
    logic        full, empty, chk_hit1, chk_hit2;

    regfile_write_queue #(.DATA_W(16), .ADDR_W(4), .REG_CNT(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_data(wr_data), .count(count), .full(full), .empty(empty),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
    endtask

    typedef struct {
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        int          cnt;
        logic        mrdy;
        logic        ardy;
        logic [15:0] we;
        logic [15:0] wd;
    } vec_t;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    vec_t vt [20];
    ent_t q [$];

    initial begin
        // Each row: inputs for this cycle, outputs expected before the next edge.
        vt[0]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'hBEEF, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1, 1'b1, 1'b1, 16'h0020, 16'hBEEF};
        vt[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[3]  = '{1'b1, 4'd3, 16'h1111, 1'b1, 4'd4, 16'h2222, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 2, 1'b1, 1'b1, 16'h0008, 16'h1111};
        vt[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1, 1'b1, 1'b1, 16'h0010, 16'h2222};
        vt[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[9]  = '{1'b1, 4'd2, 16'hA001, 1'b1, 4'd1, 16'hB001, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[10] = '{1'b1, 4'd2, 16'hA002, 1'b1, 4'd1, 16'hB002, 2, 1'b1, 1'b1, 16'h0004, 16'hA001};
        vt[11] = '{1'b1, 4'd2, 16'hA003, 1'b1, 4'd1, 16'hB003, 3, 1'b1, 1'b0, 16'h0002, 16'hB001};
        vt[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 3, 1'b1, 1'b1, 16'h0004, 16'hA002};
        vt[13] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 2, 1'b1, 1'b1, 16'h0002, 16'hB002};
        vt[14] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1, 1'b1, 1'b1, 16'h0004, 16'hA003};
        vt[15] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[16] = '{1'b1, 4'd6, 16'h0A0A, 1'b1, 4'd6, 16'h0B0B, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vt[17] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 2, 1'b1, 1'b1, 16'h0040, 16'h0A0A};
        vt[18] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1, 1'b1, 1'b1, 16'h0040, 16'h0B0B};
        vt[19] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 0, 1'b1, 1'b1, 16'h0000, 16'h0000};

        rst = 1'b0;
        chk_reg1 = 4'd0; chk_reg2 = 4'd0;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_hit1", 32'(chk_hit1), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vt[i].mv, vt[i].mr, vt[i].md, vt[i].av, vt[i].ar, vt[i].ad);
            #1;
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].cnt == 0));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].cnt == DEPTH));
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vt[i].mrdy));
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vt[i].ardy));
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vt[i].we));
            chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vt[i].wd));
            chk($sformatf("v%0d_hit1", i), 32'(chk_hit1), 32'd0);
        end

        // Hazard lookup on a queued r7 write, then after it drains.
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h7777);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        chk_reg1 = 4'd7; chk_reg2 = 4'd0;
        #1;
        chk("hz_wr_en", 32'(wr_en), 32'h0080);
        chk("hz_hit1", 32'(chk_hit1), 32'(HZ));
        chk("hz_hit2_r0", 32'(chk_hit2), 32'd0);
        chk_reg2 = 4'd7;
        #1;
        chk("hz_hit2", 32'(chk_hit2), 32'(HZ));
        chk_reg2 = 4'd3;
        #1;
        chk("hz_hit2_miss", 32'(chk_hit2), 32'd0);
        @(negedge clk);
        #1;
        chk("hz_drained_hit1", 32'(chk_hit1), 32'd0);
        chk("hz_drained_empty", 32'(empty), 32'd1);
        chk_reg1 = 4'd0; chk_reg2 = 4'd0;

        // Asynchronous reset between edges with three writes pending.
        @(negedge clk);
        drive(1'b1, 4'd2, 16'hC001, 1'b1, 4'd1, 16'hD001);
        @(negedge clk);
        drive(1'b1, 4'd2, 16'hC002, 1'b1, 4'd1, 16'hD002);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        #1;
        chk("ar_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        chk("ar_wr_en", 32'(wr_en), 32'd0);
        chk("ar_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("ar_post%0d_wr_en", i), 32'(wr_en), 32'd0);
            chk($sformatf("ar_post%0d_count", i), 32'(count), 32'd0);
        end

        // Random traffic against a queue model.
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        mv, av, emr, ear, eh1, eh2;
            logic [3:0]  mr, ar;
            logic [15:0] md, ad, ewe, ewd;
            int          sz;
            @(negedge clk);
            mv = ($urandom_range(0, 9) < 6);
            av = ($urandom_range(0, 9) < 7);
            mr = 4'($urandom_range(0, 15));
            ar = 4'($urandom_range(0, 15));
            md = 16'($urandom);
            ad = 16'($urandom);
            drive(mv, mr, md, av, ar, ad);
            chk_reg1 = 4'($urandom_range(0, 15));
            chk_reg2 = 4'($urandom_range(0, 15));
            #1;
            sz  = q.size();
            emr = (sz < DEPTH);
            ear = ((DEPTH - sz) >= 2) || ((sz < DEPTH) && !mv);
            ewe = (sz == 0) ? 16'h0 : (16'h1 << q[0].r);
            ewd = (sz == 0) ? 16'h0 : q[0].d;
            eh1 = 1'b0; eh2 = 1'b0;
            foreach (q[k]) begin
                if (q[k].r == chk_reg1 && chk_reg1 != 0) eh1 = HZ;
                if (q[k].r == chk_reg2 && chk_reg2 != 0) eh2 = HZ;
            end
            chk("rnd_count", 32'(count), 32'(sz));
            chk("rnd_empty", 32'(empty), 32'(sz == 0));
            chk("rnd_full", 32'(full), 32'(sz == DEPTH));
            chk("rnd_mem_ready", 32'(mem_ready), 32'(emr));
            chk("rnd_alu_ready", 32'(alu_ready), 32'(ear));
            chk("rnd_wr_en", 32'(wr_en), 32'(ewe));
            chk("rnd_wr_data", 32'(wr_data), 32'(ewd));
            chk("rnd_hit1", 32'(chk_hit1), 32'(eh1));
            chk("rnd_hit2", 32'(chk_hit2), 32'(eh2));
            @(posedge clk);
            if (sz > 0) void'(q.pop_front());
            if (mv && emr && mr != 0) q.push_back('{mr, md});
            if (av && ear && ar != 0) q.push_back('{ar, ad});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
